// File: rtl/pc_trace_pkg.sv
// pc_trace_pkg: serializer state encoding and UART frame constants shared by the PC trace link.
package pc_trace_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  localparam int DATA_BITS       = 8;
  localparam int STOP_BITS       = 1;
  localparam int CLK_DIV_DEFAULT = 868;
endpackage

// File: rtl/pc_trace_fifo.sv
// pc_trace_fifo: synchronous FIFO; pointers carry an extra wrap bit so full and empty are distinguishable.
module pc_trace_fifo #(
  parameter  int DEPTH = 16,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  cnt_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic         wr;
  always_comb begin
    full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    empty_o = wptr_q == rptr_q;
    wr      = push_i && (!full_o || pop_i);
    wptr_d  = wptr_q + (AW+1)'(wr);
    rptr_d  = rptr_q + (AW+1)'(pop_i && !empty_o);
    cnt_o   = wptr_q - rptr_q;
    data_o  = mem_q[rptr_q[AW-1:0]];
  end
  always_ff @(posedge clk_i)
    if (wr) mem_q[wptr_q[AW-1:0]] <= data_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
endmodule

// File: rtl/pc_trace_uart_tx.sv
// pc_trace_uart_tx: samples the PC on each stepped-CPU rising edge, queues it and sends it as a UART frame.
// Define UART_TX_PARITY_EN for 8E1 frames (even parity after the data bits); default build is 8N1.
module pc_trace_uart_tx
  import pc_trace_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEFAULT,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_clk_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic              trace_en_i,
  input  logic              ovf_clr_i,
  output logic              uart_tx_o,
  output logic              busy_o,
  output logic              ovf_o,
  output logic [4:0]        fifo_cnt_o
);
  localparam int BW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLK_DIV - 1);
`ifdef UART_TX_PARITY_EN
  localparam state_e AFTER_DATA = PARITY;
  logic par_q, par_d;
`else
  localparam state_e AFTER_DATA = STOP;
`endif
  state_e            state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic              prev_q, prev_d, pend_q, pend_d, ovf_q, ovf_d;
  logic [DATA_W-1:0] pc_q, pc_d, shift_q, shift_d, fifo_data;
  logic [BW-1:0]     baud_q, baud_d;
  logic [2:0]        idx_q, idx_d;
  logic              rise, tick, pop, full, empty, drop;
  logic [AW:0]       cnt;
  pc_trace_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (pend_q),
    .data_i  (pc_q),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (full),
    .empty_o (empty),
    .cnt_o   (cnt)
  );
  always_comb begin
    sync_d  = {sync_q[0], cpu_clk_i};
    prev_d  = sync_q[1];
    rise    = sync_q[1] && !prev_q;
    pc_d    = rise ? pc_i : pc_q;
    pend_d  = rise && trace_en_i;
    tick    = baud_q == '0;
    // a finishing stop bit hands straight over to the next start bit when data is waiting
    pop     = !empty && (state_q == IDLE || (state_q == STOP && tick));
    drop    = pend_q && full && !pop;
    ovf_d   = drop || (ovf_q && !ovf_clr_i);
    state_d = state_q;
    baud_d  = (state_q == IDLE || tick) ? BAUD_LOAD : baud_q - 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    if (tick)
      case (state_q)
        START: state_d = DATA;
        DATA: begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'(DATA_BITS - 1)) state_d = AFTER_DATA;
        end
`ifdef UART_TX_PARITY_EN
        PARITY: state_d = STOP;
`endif
        STOP: state_d = IDLE;
        default: ;
      endcase
    if (pop) begin
      state_d = START;
      shift_d = fifo_data;
      idx_d   = '0;
    end
`ifdef UART_TX_PARITY_EN
    par_d = pop ? ^fifo_data : par_q;
`endif
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      pc_q    <= '0;
      shift_q <= '0;
      baud_q  <= BAUD_LOAD;
      idx_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      pc_q    <= pc_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  always_comb begin
    uart_tx_o = state_q == START ? 1'b0 :
                state_q == DATA  ? shift_q[0] :
`ifdef UART_TX_PARITY_EN
                state_q == PARITY ? par_q :
`endif
                1'b1;
    busy_o     = state_q != IDLE || !empty;
    ovf_o      = ovf_q;
    fifo_cnt_o = 5'(cnt);
  end
endmodule

// File: tb/tb_pc_trace_uart_tx.sv
// tb_pc_trace_uart_tx: directed checks of the PC trace UART transmitter with CLK_DIV=4, FIFO_DEPTH=4.
module tb_pc_trace_uart_tx;
  localparam int CLK_DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic       clk_i = 0, rst_ni = 0, cpu_clk_i = 0, trace_en_i = 1, ovf_clr_i = 0;
  logic [7:0] pc_i = 0;
  logic       uart_tx_o, busy_o, ovf_o;
  logic [4:0] fifo_cnt_o;
  int         total = 0, bad = 0;
  pc_trace_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(4), .DATA_W(8)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .cpu_clk_i  (cpu_clk_i),
    .pc_i       (pc_i),
    .trace_en_i (trace_en_i),
    .ovf_clr_i  (ovf_clr_i),
    .uart_tx_o  (uart_tx_o),
    .busy_o     (busy_o),
    .ovf_o      (ovf_o),
    .fifo_cnt_o (fifo_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic pulse(input logic [7:0] pc);
    pc_i = pc;
    cpu_clk_i = 1;
    repeat (2) @(negedge clk_i);
    cpu_clk_i = 0;
    repeat (2) @(negedge clk_i);
  endtask
  task automatic quiet(input string tag, input int n);
    int lows = 0;
    repeat (n) begin
      if (uart_tx_o !== 1'b1) lows++;
      @(negedge clk_i);
    end
    chk(tag, lows, 0);
  endtask
  task automatic rx_expect(input string tag, input logic [7:0] exp, output int gap);
    logic [NB-1:0] bits;
    logic cons;
    gap = 0;
    while (uart_tx_o !== 1'b0 && gap < 100) begin
      @(negedge clk_i);
      gap++;
    end
    chk({tag, "_start_seen"}, gap < 100, 1);
    if (gap >= 100) return;
    cons = 1;
    for (int b = 0; b < NB; b++) begin
      bits[b] = uart_tx_o;
      for (int s = 0; s < CLK_DIV; s++) begin
        if (uart_tx_o !== bits[b]) cons = 0;
        @(negedge clk_i);
      end
    end
    chk({tag, "_bit_width"}, cons, 1);
    chk({tag, "_start"}, bits[0], 0);
    chk({tag, "_data"}, bits[8:1], exp);
`ifdef UART_TX_PARITY_EN
    chk({tag, "_parity"}, bits[9], ^exp);
`endif
    chk({tag, "_stop"}, bits[NB-1], 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    int gap;
    repeat (3) @(negedge clk_i);
    chk("rst_tx", uart_tx_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_cnt", fifo_cnt_o, 0);
    rst_ni = 1;
    @(negedge clk_i);
    quiet("idle_after_rst", 8);
    pulse(8'hA5);
    chk("single_busy", busy_o, 1);
    rx_expect("single", 8'hA5, gap);
    chk("single_busy_done", busy_o, 0);
    chk("single_cnt", fifo_cnt_o, 0);
    quiet("single_idle", 10);
    fork
      begin
        pulse(8'h01);
        pulse(8'h02);
        pulse(8'h03);
        repeat (2) @(negedge clk_i);
        chk("b2b_cnt_queued", fifo_cnt_o, 2);
      end
      begin
        rx_expect("b2b_f1", 8'h01, gap);
        chk("b2b_cnt_f2", fifo_cnt_o, 1);
        rx_expect("b2b_f2", 8'h02, gap);
        chk("b2b_gap2", gap, 0);
        chk("b2b_cnt_f3", fifo_cnt_o, 0);
        rx_expect("b2b_f3", 8'h03, gap);
        chk("b2b_gap3", gap, 0);
      end
    join
    chk("b2b_busy_done", busy_o, 0);
    quiet("b2b_idle", 10);
    fork
      begin
        for (int i = 0; i < 6; i++) pulse(8'(8'h10 + i));
        repeat (2) @(negedge clk_i);
        chk("ovf_set", ovf_o, 1);
        chk("ovf_cnt_full", fifo_cnt_o, 4);
      end
      begin
        for (int i = 0; i < 5; i++) rx_expect("ovf_frame", 8'(8'h10 + i), gap);
      end
    join
    quiet("ovf_no_sixth", 60);
    chk("ovf_sticky", ovf_o, 1);
    ovf_clr_i = 1;
    @(negedge clk_i);
    ovf_clr_i = 0;
    chk("ovf_cleared", ovf_o, 0);
    trace_en_i = 0;
    pulse(8'h55);
    pulse(8'h56);
    pulse(8'h57);
    quiet("en_off_quiet", 20);
    chk("en_off_cnt", fifo_cnt_o, 0);
    chk("en_off_busy", busy_o, 0);
    trace_en_i = 1;
    pulse(8'h3C);
    rx_expect("en_on", 8'h3C, gap);
    quiet("en_on_single", 50);
`ifdef UART_TX_PARITY_EN
    pulse(8'h07);
    rx_expect("par_07", 8'h07, gap);
    pulse(8'h03);
    rx_expect("par_03", 8'h03, gap);
    quiet("par_idle", 20);
`endif
    for (int i = 0; i < 6; i++) pulse(8'(8'h20 + i));
    chk("mid_ovf_set", ovf_o, 1);
    chk("mid_cnt_full", fifo_cnt_o, 4);
    chk("mid_tx_low", uart_tx_o, 0);
    #2 rst_ni = 0;
    #1;
    chk("mid_rst_tx", uart_tx_o, 1);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_cnt", fifo_cnt_o, 0);
    chk("mid_rst_ovf", ovf_o, 0);
    @(negedge clk_i);
    rst_ni = 1;
    quiet("mid_rst_idle", 20);
    chk("mid_rst_cnt_after", fifo_cnt_o, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
